// File: rtl/tx_frame_packer_if.sv
// Byte-stream ingress and Tx_mac word egress of tx_frame_packer.
// slave = the packer; master = the source/MAC environment around it.
interface tx_frame_packer_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_ready;
    logic        tx_mac_wa;
    logic        tx_mac_wr;
    logic [31:0] tx_mac_data;
    logic [1:0]  tx_mac_be;
    logic        tx_mac_sop;
    logic        tx_mac_eop;

    modport slave (
        input  in_valid, in_data, in_last, tx_mac_wa,
        output in_ready, tx_mac_wr, tx_mac_data, tx_mac_be, tx_mac_sop, tx_mac_eop
    );
    modport master (
        output in_valid, in_data, in_last, tx_mac_wa,
        input  in_ready, tx_mac_wr, tx_mac_data, tx_mac_be, tx_mac_sop, tx_mac_eop
    );
endinterface

// File: rtl/tx_frame_packer.sv
// Store-and-forward byte-to-word packer feeding the MAC Tx_mac_* interface.
// Optional: define TX_PAD_EN to zero-pad short frames to 60 bytes.
module tx_frame_packer #(
    parameter int DEPTH_WORDS = 512,
    parameter int MAX_BYTES   = 1514,
    parameter int PEND_W      = 8
) (
    input  logic               clk_user,
    input  logic               reset,
    tx_frame_packer_if.slave   bus,
    output logic [PEND_W-1:0]  frames_pending,
    output logic [15:0]        trunc_cnt
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [AW:0]       DEPTH_CNT = (AW+1)'(DEPTH_WORDS);
    localparam logic [AW:0]       PTR_ONE   = (AW+1)'(1);
    localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
    localparam logic [10:0]       MAX_CNT   = 11'(MAX_BYTES);
    localparam logic [10:0]       MIN_BYTES = 11'd60;
`ifdef TX_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    typedef struct packed {
        logic        last;
        logic [1:0]  be;
        logic [31:0] data;
    } fifo_word_t;

    typedef enum logic [1:0] {W_PACK, W_DROP, W_PAD} wstate_t;
    typedef enum logic {R_IDLE, R_SEND} rstate_t;

    wstate_t wstate, wstate_nxt;
    rstate_t rstate, rstate_nxt;

    fifo_word_t  mem [DEPTH_WORDS];
    fifo_word_t  head, push_word;
    logic [AW:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, count, count_nxt;

    logic [31:0] stage, word_nxt;
    logic [1:0]  byte_idx;
    logic [10:0] frame_cnt, n_bytes;
    logic [3:0]  pad_words, pad_base;
    logic        first_word;
    logic        in_ready_q, in_ready_nxt;
    logic        accept, push, pop, trunc_hit, pad_start;
    logic        push_last, pop_last;
    logic [PEND_W-1:0] pend_nxt;

    assign accept   = bus.in_valid & in_ready_q;
    assign n_bytes  = frame_cnt + 11'd1;
    // words already holding frame data once the current byte is in
    assign pad_base = n_bytes[5:2] + {3'b000, |n_bytes[1:0]};
    assign bus.in_ready = in_ready_q;

    always_comb begin
        word_nxt = stage;
        case (byte_idx)
            2'd0:    word_nxt[31:24] = bus.in_data;
            2'd1:    word_nxt[23:16] = bus.in_data;
            2'd2:    word_nxt[15:8]  = bus.in_data;
            default: word_nxt[7:0]   = bus.in_data;
        endcase
    end

    // ---------------- write-side FSM ----------------
    always_ff @(posedge clk_user or negedge reset) begin
        if (!reset) wstate <= W_PACK;
        else        wstate <= wstate_nxt;
    end

    always_comb begin
        wstate_nxt = wstate;
        push       = 1'b0;
        push_word  = '0;
        trunc_hit  = 1'b0;
        pad_start  = 1'b0;
        case (wstate)
            W_PACK: begin
                if (accept) begin
                    trunc_hit      = (n_bytes == MAX_CNT) && !bus.in_last;
                    push_word.data = word_nxt;
                    push           = (byte_idx == 2'd3) || bus.in_last || trunc_hit;
                    if (bus.in_last || trunc_hit) begin
                        push_word.last = 1'b1;
                        push_word.be   = n_bytes[1:0];
                    end
                    // short frame: zero-filled tail, padding words follow unless this is word 15
                    if (PAD_EN && bus.in_last && (n_bytes < MIN_BYTES)) begin
                        push_word.be = 2'b00;
                        if (pad_base != 4'd15) begin
                            push_word.last = 1'b0;
                            pad_start      = 1'b1;
                            wstate_nxt     = W_PAD;
                        end
                    end
                    if (trunc_hit) wstate_nxt = W_DROP;
                end
            end
            W_DROP: begin
                if (accept && bus.in_last) wstate_nxt = W_PACK;
            end
            W_PAD: begin
                if (count != DEPTH_CNT) begin
                    push           = 1'b1;
                    push_word.last = (pad_words == 4'd14);
                    if (push_word.last) wstate_nxt = W_PACK;
                end
            end
            default: wstate_nxt = W_PACK;
        endcase
    end

    always_ff @(posedge clk_user or negedge reset) begin
        if (!reset) begin
            stage     <= '0;
            byte_idx  <= '0;
            frame_cnt <= '0;
            pad_words <= '0;
            trunc_cnt <= '0;
        end else begin
            if (wstate == W_PACK && accept) begin
                if (push) begin
                    stage    <= '0;
                    byte_idx <= '0;
                end else begin
                    stage    <= word_nxt;
                    byte_idx <= byte_idx + 2'd1;
                end
                frame_cnt <= (bus.in_last || trunc_hit) ? 11'd0 : n_bytes;
            end
            if (pad_start)
                pad_words <= pad_base;
            else if (wstate == W_PAD && push)
                pad_words <= pad_words + 4'd1;
            if (trunc_hit && trunc_cnt != 16'hFFFF)
                trunc_cnt <= trunc_cnt + 16'd1;
        end
    end

    // ---------------- word FIFO ----------------
    always_ff @(posedge clk_user) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_word;
    end

    assign head       = mem[rd_ptr[AW-1:0]];
    assign pop        = bus.tx_mac_wr;
    assign push_last  = push & push_word.last;
    assign pop_last   = pop & head.last;
    assign wr_ptr_nxt = push ? wr_ptr + PTR_ONE : wr_ptr;
    assign rd_ptr_nxt = pop  ? rd_ptr + PTR_ONE : rd_ptr;
    assign count      = wr_ptr - rd_ptr;
    assign count_nxt  = wr_ptr_nxt - rd_ptr_nxt;

    always_comb begin
        pend_nxt = frames_pending;
        if (push_last && !pop_last)
            pend_nxt = frames_pending + PEND_ONE;
        else if (!push_last && pop_last)
            pend_nxt = frames_pending - PEND_ONE;
    end

    // in_ready reflects the state and occupancy after this edge
    always_comb begin
        in_ready_nxt = 1'b0;
        case (wstate_nxt)
            W_DROP:  in_ready_nxt = 1'b1;
            W_PAD:   in_ready_nxt = 1'b0;
            default: in_ready_nxt = (count_nxt != DEPTH_CNT) && (pend_nxt != '1);
        endcase
    end

    always_ff @(posedge clk_user or negedge reset) begin
        if (!reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            frames_pending <= '0;
            in_ready_q     <= 1'b0;
            first_word     <= 1'b1;
        end else begin
            wr_ptr         <= wr_ptr_nxt;
            rd_ptr         <= rd_ptr_nxt;
            frames_pending <= pend_nxt;
            in_ready_q     <= in_ready_nxt;
            if (pop) first_word <= head.last;
        end
    end

    // ---------------- read-side FSM ----------------
    always_ff @(posedge clk_user or negedge reset) begin
        if (!reset) rstate <= R_IDLE;
        else        rstate <= rstate_nxt;
    end

    always_comb begin
        rstate_nxt      = rstate;
        bus.tx_mac_wr   = 1'b0;
        bus.tx_mac_data = '0;
        bus.tx_mac_be   = 2'b00;
        bus.tx_mac_sop  = 1'b0;
        bus.tx_mac_eop  = 1'b0;
        case (rstate)
            R_IDLE: begin
                if (pend_nxt != '0) rstate_nxt = R_SEND;
            end
            R_SEND: begin
                bus.tx_mac_wr   = bus.tx_mac_wa;
                bus.tx_mac_data = head.data;
                bus.tx_mac_be   = head.last ? head.be : 2'b00;
                bus.tx_mac_sop  = first_word;
                bus.tx_mac_eop  = head.last;
                if (bus.tx_mac_wa && head.last) rstate_nxt = R_IDLE;
            end
            default: rstate_nxt = R_IDLE;
        endcase
    end
endmodule

// File: tb/tb_tx_frame_packer.sv
// Directed bench for tx_frame_packer: scoreboard of expected MAC words, checked on each tx_mac_wr.
module tb_tx_frame_packer;
    localparam int MAXB = 1514;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  be;
        logic        sop;
        logic        eop;
    } exp_t;

    logic        clk_user = 1'b0;
    logic        reset    = 1'b0;
    logic [7:0]  frames_pending;
    logic [15:0] trunc_cnt;

    tx_frame_packer_if bus();

    tx_frame_packer #(.DEPTH_WORDS(512), .MAX_BYTES(MAXB), .PEND_W(8)) dut (
        .clk_user       (clk_user),
        .reset          (reset),
        .bus            (bus),
        .frames_pending (frames_pending),
        .trunc_cnt      (trunc_cnt)
    );

    always #5 clk_user = ~clk_user;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks   = 0;
    int   n_errors   = 0;
    int   words_seen = 0;
    logic prev_eop   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] bv(input int seed, input int i);
        return 8'(seed * 31 + i * 13 + i / 256);
    endfunction

    function automatic logic [31:0] be_mask(input logic [1:0] be);
        case (be)
            2'b01:   return 32'hFF00_0000;
            2'b10:   return 32'hFFFF_0000;
            2'b11:   return 32'hFFFF_FF00;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    // monitor: every word written to the MAC must match the scoreboard head
    always @(negedge clk_user) begin
        if (reset && bus.tx_mac_wr) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_word", 32'(sb_q.size()), 32'd1);
            end else begin
                mon_e = sb_q.pop_front();
                chk("data", bus.tx_mac_data & be_mask(mon_e.be), mon_e.data & be_mask(mon_e.be));
                chk("be",   32'(bus.tx_mac_be),  32'(mon_e.be));
                chk("sop",  32'(bus.tx_mac_sop), 32'(mon_e.sop));
                chk("eop",  32'(bus.tx_mac_eop), 32'(mon_e.eop));
                if (mon_e.sop) chk("idle_gap", 32'(prev_eop), 32'd0);
            end
            words_seen++;
        end
        prev_eop = reset && bus.tx_mac_wr && bus.tx_mac_eop;
    end

    task automatic expect_frame(input int len, input int seed);
        int   eff, nb, nw, idx;
        exp_t e;
        eff = (len > MAXB) ? MAXB : len;
        nb  = eff;
`ifdef TX_PAD_EN
        if (nb < 60) nb = 60;
`endif
        nw = (nb + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            e.data = '0;
            for (int b = 0; b < 4; b++) begin
                idx = w * 4 + b;
                e.data[31 - 8 * b -: 8] = (idx < eff) ? bv(seed, idx) : 8'h00;
            end
            e.sop = (w == 0);
            e.eop = (w == nw - 1);
            e.be  = e.eop ? 2'(nb % 4) : 2'b00;
            sb_q.push_back(e);
        end
    endtask

    // call just after a negedge; returns at the negedge following acceptance
    task automatic put_byte(input logic [7:0] d, input logic l);
        int guard;
        bit acc;
        guard = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        forever begin
            acc = bus.in_ready;
            @(negedge clk_user);
            if (acc) break;
            guard++;
            if (guard > 2000) begin
                chk("in_ready_timeout", 32'(acc), 32'd1);
                break;
            end
        end
    endtask

    task automatic send_bytes(input int len, input int seed, input bit with_last);
        for (int i = 0; i < len; i++) put_byte(bv(seed, i), with_last && (i == len - 1));
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic send_frame(input int len, input int seed);
        expect_frame(len, seed);
        send_bytes(len, seed, 1'b1);
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while (sb_q.size() != 0 && g < 5000) begin
            @(negedge clk_user);
            g++;
        end
        chk("drain", 32'(sb_q.size()), 32'd0);
        repeat (3) @(negedge clk_user);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(bus.in_ready),    32'd0);
        chk({tag, "_wr"},       32'(bus.tx_mac_wr),   32'd0);
        chk({tag, "_sop"},      32'(bus.tx_mac_sop),  32'd0);
        chk({tag, "_eop"},      32'(bus.tx_mac_eop),  32'd0);
        chk({tag, "_be"},       32'(bus.tx_mac_be),   32'd0);
        chk({tag, "_data"},     bus.tx_mac_data,      32'd0);
        chk({tag, "_pending"},  32'(frames_pending),  32'd0);
        chk({tag, "_trunc"},    32'(trunc_cnt),       32'd0);
    endtask

    initial begin
        int base, cnt, g;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_last   = 1'b0;
        bus.tx_mac_wa = 1'b0;

        // reset state
        repeat (3) @(negedge clk_user);
        check_reset_outputs("reset");
        reset = 1'b1;
        bus.tx_mac_wa = 1'b1;
        @(negedge clk_user);
        chk("in_ready_after_reset", 32'(bus.in_ready), 32'd1);

        // 84-byte frame: 21 words, pending 1 then 0
        base = words_seen;
        send_frame(84, 1);
        chk("pending_one", 32'(frames_pending), 32'd1);
        wait_drain();
        chk("pending_zero", 32'(frames_pending), 32'd0);
        chk("words_84", 32'(words_seen - base), 32'd21);

        // 61-byte frame: 16 words, eop be=01
        base = words_seen;
        send_frame(61, 2);
        wait_drain();
        chk("words_61", 32'(words_seen - base), 32'd16);

        // 84-byte frame with wa held low at word 7
        base = words_seen;
        send_frame(84, 3);
        cnt = 0;
        g   = 0;
        forever begin
            if (bus.tx_mac_wr) cnt++;
            if (cnt == 7 || g > 200) break;
            @(negedge clk_user);
            g++;
        end
        chk("reach_word7", 32'(cnt), 32'd7);
        @(posedge clk_user);
        #1 bus.tx_mac_wa = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_user);
            chk("stall_wr", 32'(bus.tx_mac_wr), 32'd0);
            if (sb_q.size() != 0) chk("stall_hold", bus.tx_mac_data, sb_q[0].data);
        end
        bus.tx_mac_wa = 1'b1;
        wait_drain();
        chk("words_stall", 32'(words_seen - base), 32'd21);

        // 1600-byte frame truncated to 1514, then an intact 64-byte frame
        base = words_seen;
        send_frame(1600, 4);
        chk("trunc_one", 32'(trunc_cnt), 32'd1);
        send_frame(64, 5);
        wait_drain();
        chk("words_trunc", 32'(words_seen - base), 32'd395);
        chk("trunc_still_one", 32'(trunc_cnt), 32'd1);

        // three back-to-back frames held, then released
        base = words_seen;
        bus.tx_mac_wa = 1'b0;
        send_frame(64, 6);
        send_frame(64, 7);
        send_frame(64, 8);
        @(negedge clk_user);
        chk("pending_three", 32'(frames_pending), 32'd3);
        bus.tx_mac_wa = 1'b1;
        wait_drain();
        chk("words_b2b", 32'(words_seen - base), 32'd48);
        chk("pending_after_b2b", 32'(frames_pending), 32'd0);

        // reset in the middle of a frame
        send_bytes(30, 9, 1'b0);
        #2 reset = 1'b0;
        #1 check_reset_outputs("midreset");
        @(negedge clk_user);
        reset = 1'b1;
        @(negedge clk_user);
        base = words_seen;
        send_frame(20, 10);
        wait_drain();
`ifdef TX_PAD_EN
        chk("words_after_reset", 32'(words_seen - base), 32'd15);
`else
        chk("words_after_reset", 32'(words_seen - base), 32'd5);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
